// File: rtl/zeroheti_pkg.sv
// Shared types and defaults for the zeroheti APB arbiter slice.
package zeroheti_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    localparam int unsigned ArbTimeout = 32'd255;

endpackage

// File: rtl/zeroheti_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module zeroheti_rr_pick
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumMgrs = 32'd2
) (
    input  logic [NumMgrs-1:0]         req,
    input  logic [$clog2(NumMgrs)-1:0] ptr,
    output logic [$clog2(NumMgrs)-1:0] idx,
    output logic                       valid
);

    localparam int unsigned IdxW = $clog2(NumMgrs);

    int unsigned pos;

    // Walk offsets from the far end so the closest request to the pointer is written last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = 32'd0;
        for (int k = NumMgrs - 1; k >= 0; k--) begin
            pos   = (int'(ptr) + k) % NumMgrs;
            idx   = req[pos] ? IdxW'(pos) : idx;
            valid = valid | req[pos];
        end
    end

endmodule

// File: rtl/zeroheti_apb_arbiter.sv
// Round-robin arbiter serialising NumMgrs APB managers onto one subordinate port,
// with a clean setup/access re-issue and a timeout that errors out hung accesses.
module zeroheti_apb_arbiter
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumMgrs       = 32'd2,
    parameter int unsigned AddrWidth     = 32'd32,
    parameter int unsigned DataWidth     = 32'd32,
    parameter int unsigned TimeoutCycles = ArbTimeout
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumMgrs-1:0]                  mgr_psel_i,
    input  logic [NumMgrs-1:0]                  mgr_penable_i,
    input  logic [NumMgrs-1:0]                  mgr_pwrite_i,
    input  logic [NumMgrs-1:0][AddrWidth-1:0]   mgr_paddr_i,
    input  logic [NumMgrs-1:0][DataWidth-1:0]   mgr_pwdata_i,
    output logic [NumMgrs-1:0][DataWidth-1:0]   mgr_prdata_o,
    output logic [NumMgrs-1:0]                  mgr_pready_o,
    output logic [NumMgrs-1:0]                  mgr_pslverr_o,
    output logic                                sub_psel_o,
    output logic                                sub_penable_o,
    output logic                                sub_pwrite_o,
    output logic [AddrWidth-1:0]                sub_paddr_o,
    output logic [DataWidth-1:0]                sub_pwdata_o,
    input  logic [DataWidth-1:0]                sub_prdata_i,
    input  logic                                sub_pready_i,
    input  logic                                sub_pslverr_i,
    output logic [$clog2(NumMgrs)-1:0]          grant_o,
    output logic                                busy_o,
    output logic                                timeout_o
);

    localparam int unsigned IdxW      = $clog2(NumMgrs);
    localparam bit          TimeoutEn = (TimeoutCycles != 32'd0);
    localparam int unsigned CntW      = TimeoutEn ? $clog2(TimeoutCycles + 32'd1) : 32'd1;
    // cnt_r counts completed access cycles, so the deciding cycle is TimeoutCycles-1.
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 32'd1);
    localparam logic [CntW-1:0] CntMax  = TimeoutEn ? CntW'(TimeoutCycles) : {CntW{1'b1}};

    arb_state_e             state_r;
    logic [IdxW-1:0]        ptr_r;
    logic [IdxW-1:0]        grant_r;
    logic [CntW-1:0]        cnt_r;
    logic                   sub_psel_r;
    logic                   sub_penable_r;
    logic                   sub_pwrite_r;
    logic [AddrWidth-1:0]   sub_paddr_r;
    logic [DataWidth-1:0]   sub_pwdata_r;
    logic [IdxW-1:0]        pick_idx_s;
    logic                   pick_valid_s;
    logic                   timeout_hit_s;
    logic                   unused_penable_s;

    // Arbitration is decided from psel alone; penable carries no information here.
    assign unused_penable_s = ^mgr_penable_i;

    zeroheti_rr_pick #(
        .NumMgrs (NumMgrs)
    ) u_pick (
        .req   (mgr_psel_i),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    assign timeout_hit_s = TimeoutEn && (cnt_r == CntLast);

    // Arbiter FSM with registered subordinate-side outputs.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_r       <= IDLE;
            ptr_r         <= '0;
            grant_r       <= '0;
            cnt_r         <= '0;
            sub_psel_r    <= 1'b0;
            sub_penable_r <= 1'b0;
            sub_pwrite_r  <= 1'b0;
            sub_paddr_r   <= '0;
            sub_pwdata_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_r      <= pick_idx_s;
                        ptr_r        <= (pick_idx_s == IdxW'(NumMgrs - 32'd1)) ? '0
                                        : pick_idx_s + IdxW'(1);
                        sub_psel_r   <= 1'b1;
                        sub_pwrite_r <= mgr_pwrite_i[pick_idx_s];
                        sub_paddr_r  <= mgr_paddr_i[pick_idx_s];
                        sub_pwdata_r <= mgr_pwdata_i[pick_idx_s];
                        state_r      <= SETUP;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                SETUP: begin
                    sub_penable_r <= 1'b1;
                    cnt_r         <= '0;
                    state_r       <= ACCESS;
                end
                ACCESS: begin
                    if (sub_pready_i || timeout_hit_s) begin
                        sub_psel_r    <= 1'b0;
                        sub_penable_r <= 1'b0;
                        sub_pwrite_r  <= 1'b0;
                        sub_paddr_r   <= '0;
                        sub_pwdata_r  <= '0;
                        state_r       <= IDLE;
                    end else if (cnt_r != CntMax) begin
                        cnt_r <= cnt_r + CntW'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    sub_psel_r    <= 1'b0;
                    sub_penable_r <= 1'b0;
                    sub_pwrite_r  <= 1'b0;
                    sub_paddr_r   <= '0;
                    sub_pwdata_r  <= '0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    // Completion is returned in the same cycle the subordinate (or the timeout) ends the access.
    always_comb begin
        mgr_pready_o  = '0;
        mgr_pslverr_o = '0;
        mgr_prdata_o  = '0;
        timeout_o     = 1'b0;
        case (state_r)
            ACCESS: begin
                if (sub_pready_i) begin
                    mgr_pready_o[grant_r]  = 1'b1;
                    mgr_pslverr_o[grant_r] = sub_pslverr_i;
                    mgr_prdata_o[grant_r]  = sub_prdata_i;
                end else if (timeout_hit_s) begin
                    mgr_pready_o[grant_r]  = 1'b1;
                    mgr_pslverr_o[grant_r] = 1'b1;
                    timeout_o              = 1'b1;
                end else begin
                    timeout_o              = 1'b0;
                end
            end
            default: begin
                timeout_o = 1'b0;
            end
        endcase
    end

    assign sub_psel_o    = sub_psel_r;
    assign sub_penable_o = sub_penable_r;
    assign sub_pwrite_o  = sub_pwrite_r;
    assign sub_paddr_o   = sub_paddr_r;
    assign sub_pwdata_o  = sub_pwdata_r;
    assign grant_o       = grant_r;
    assign busy_o        = (state_r != IDLE);

endmodule

// File: tb/tb_zeroheti_apb_arbiter.sv
// Scoreboard bench: a round-robin model predicts completion order, data and cycle per request.
module tb_zeroheti_apb_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic                    clk = 1'b0;
    logic                    rst_ni = 1'b1;
    logic [NM-1:0]           mgr_psel_i = '0;
    logic [NM-1:0]           mgr_penable_i = '0;
    logic [NM-1:0]           mgr_pwrite_i = '0;
    logic [NM-1:0][AW-1:0]   mgr_paddr_i = '0;
    logic [NM-1:0][DW-1:0]   mgr_pwdata_i = '0;
    logic [NM-1:0][DW-1:0]   mgr_prdata_o;
    logic [NM-1:0]           mgr_pready_o;
    logic [NM-1:0]           mgr_pslverr_o;
    logic                    sub_psel_o, sub_penable_o, sub_pwrite_o;
    logic [AW-1:0]           sub_paddr_o;
    logic [DW-1:0]           sub_pwdata_o;
    logic [DW-1:0]           sub_prdata_i = '0;
    logic                    sub_pready_i = 1'b0;
    logic                    sub_pslverr_i = 1'b0;
    logic [1:0]              grant_o;
    logic                    busy_o, timeout_o;

    typedef struct {
        int          mgr;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        tout;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          mdl_ptr = 0;
    int          wl = 0;
    logic [31:0] req_addr [NM];
    logic        req_wr   [NM];
    logic [31:0] req_wd   [NM];

    zeroheti_apb_arbiter #(
        .NumMgrs(NM), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .mgr_psel_i(mgr_psel_i), .mgr_penable_i(mgr_penable_i), .mgr_pwrite_i(mgr_pwrite_i),
        .mgr_paddr_i(mgr_paddr_i), .mgr_pwdata_i(mgr_pwdata_i),
        .mgr_prdata_o(mgr_prdata_o), .mgr_pready_o(mgr_pready_o), .mgr_pslverr_o(mgr_pslverr_o),
        .sub_psel_o(sub_psel_o), .sub_penable_o(sub_penable_o), .sub_pwrite_o(sub_pwrite_o),
        .sub_paddr_o(sub_paddr_o), .sub_pwdata_o(sub_pwdata_o),
        .sub_prdata_i(sub_prdata_i), .sub_pready_i(sub_pready_i), .sub_pslverr_i(sub_pslverr_i),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Subordinate behaviour is a pure function of the address.
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return 32'hDEAD_BEEF ^ 32'h0003_0004 ^ a;
    endfunction
    function automatic logic err_of(input logic [31:0] a);
        return a[3];
    endfunction
    function automatic logic is_hang(input logic [31:0] a);
        return a[31:28] == 4'hF;
    endfunction
    function automatic int waits_of(input logic [31:0] a);
        if (is_hang(a)) return 1000;
        if (a[31:28] == 4'hE) return TO - 1;
        return int'(a[5:4]);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic w, input logic [31:0] d);
        req_addr[m] = a;
        req_wr[m]   = w;
        req_wd[m]   = d;
    endtask

    // Simultaneous requests are served in cyclic order from the model pointer.
    task automatic issue_round(input logic [NM-1:0] mask);
        int   t;
        int   last;
        int   m;
        exp_t e;
        t    = cyc - 1;
        last = 0;
        for (int k = 0; k < NM; k++) begin
            m = (mdl_ptr + k) % NM;
            if (mask[m]) begin
                e.mgr   = m;
                e.wr    = req_wr[m];
                e.addr  = req_addr[m];
                e.wdata = req_wd[m];
                e.tout  = is_hang(req_addr[m]);
                e.rdata = e.tout ? 32'h0 : rd_of(req_addr[m]);
                e.err   = e.tout ? 1'b1 : err_of(req_addr[m]);
                t       = t + 3 + (e.tout ? TO - 1 : waits_of(req_addr[m]));
                e.cyc   = t;
                sb_q.push_back(e);
                last    = m;
                mgr_psel_i[m]   = 1'b1;
                mgr_pwrite_i[m] = req_wr[m];
                mgr_paddr_i[m]  = req_addr[m];
                mgr_pwdata_i[m] = req_wd[m];
            end
        end
        mdl_ptr = (last + 1) % NM;
    endtask

    task automatic wait_round();
        int budget;
        budget = 300;
        while (mgr_psel_i != '0 && budget > 0) begin
            @(negedge clk);
            mgr_penable_i = mgr_psel_i;
            for (int m = 0; m < NM; m++) begin
                if (mgr_pready_o[m]) begin
                    mgr_psel_i[m]    = 1'b0;
                    mgr_penable_i[m] = 1'b0;
                end
            end
            budget--;
        end
        if (budget == 0) begin
            chk("round_timeout", 128'(mgr_psel_i), 128'(0));
            mgr_psel_i    = '0;
            mgr_penable_i = '0;
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 128'({sub_psel_o, sub_penable_o, sub_pwrite_o, sub_paddr_o, sub_pwdata_o,
                        mgr_pready_o, mgr_pslverr_o, grant_o, busy_o, timeout_o}), 128'(0));
        chk({name, "_prdata"}, 128'(mgr_prdata_o), 128'(0));
    endtask

    // Subordinate model: counts wait states from SETUP, garbage on the bus until ready.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_ni) begin
            sub_pready_i  = 1'b0;
            sub_prdata_i  = '0;
            sub_pslverr_i = 1'b0;
        end else if (sub_psel_o && !sub_penable_o) begin
            wl            = waits_of(sub_paddr_o);
            sub_pready_i  = 1'b0;
            sub_prdata_i  = $urandom;
            sub_pslverr_i = 1'($urandom);
        end else if (sub_psel_o && sub_penable_o && wl == 0) begin
            sub_pready_i  = 1'b1;
            sub_prdata_i  = rd_of(sub_paddr_o);
            sub_pslverr_i = err_of(sub_paddr_o);
        end else if (sub_psel_o && sub_penable_o) begin
            sub_pready_i  = 1'b0;
            sub_prdata_i  = $urandom;
            sub_pslverr_i = 1'($urandom);
            wl            = wl - 1;
        end else begin
            sub_pready_i  = 1'b0;
            sub_prdata_i  = $urandom;
            sub_pslverr_i = 1'b0;
        end
    end

    // Monitor: bus-side checks against the head transfer, then manager-side completion pops.
    initial forever begin
        exp_t                  e;
        logic [NM-1:0][DW-1:0] ev;
        logic [NM-1:0]         ep, ee;
        @(negedge clk);
        if (busy_o) begin
            if (sb_q.size() == 0) chk("busy_without_request", 128'(busy_o), 128'(0));
            else chk("sub_fields", 128'({sub_psel_o, sub_pwrite_o, sub_paddr_o, sub_pwdata_o, grant_o}),
                     128'({1'b1, sb_q[0].wr, sb_q[0].addr, sb_q[0].wdata, 2'(sb_q[0].mgr)}));
        end else begin
            chk("sub_idle_zero", 128'({sub_psel_o, sub_penable_o, sub_pwrite_o, sub_paddr_o, sub_pwdata_o}),
                128'(0));
        end
        if (mgr_pready_o != '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pready", 128'(mgr_pready_o), 128'(0));
            end else begin
                e  = sb_q.pop_front();
                ev = '0;
                ep = '0;
                ee = '0;
                ev[e.mgr] = e.rdata;
                ep[e.mgr] = 1'b1;
                ee[e.mgr] = e.err;
                chk("pready_vec", 128'(mgr_pready_o), 128'(ep));
                chk("prdata_vec", 128'(mgr_prdata_o), 128'(ev));
                chk("pslverr_vec", 128'(mgr_pslverr_o), 128'(ee));
                chk("timeout", 128'(timeout_o), 128'(e.tout));
                chk("done_cycle", 128'(cyc), 128'(e.cyc));
            end
        end else begin
            chk("quiet_outputs", 128'({timeout_o, mgr_pslverr_o, mgr_prdata_o}), 128'(0));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NM-1:0] mask;
        logic [31:0]   a;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_ni = 1'b0;
        mdl_ptr = 0;
        @(negedge clk);

        // Both managers at once after reset: 0,1 then 0,1 again.
        set_req(0, 32'h0000_0010, 1'b0, 32'h1111_0000);
        set_req(1, 32'h0000_0028, 1'b1, 32'h2222_0001);
        issue_round(3'b011);
        wait_round();
        issue_round(3'b011);
        wait_round();

        // Single zero-wait read.
        set_req(0, 32'h0003_0004, 1'b0, 32'h0);
        issue_round(3'b001);
        wait_round();

        // Hung subordinate, then pready exactly on the timeout cycle.
        set_req(0, 32'hF000_0020, 1'b0, 32'h0);
        issue_round(3'b001);
        wait_round();
        set_req(1, 32'hE000_0004, 1'b0, 32'h0);
        issue_round(3'b010);
        wait_round();

        // Write with three wait states.
        set_req(1, 32'h0000_0030, 1'b1, 32'h1234_5678);
        issue_round(3'b010);
        wait_round();

        // Reset during ACCESS of a write; the transfer is dropped.
        set_req(0, 32'h0000_0038, 1'b1, 32'hCAFE_F00D);
        issue_round(3'b001);
        @(negedge clk);
        @(negedge clk);
        chk("in_access", 128'({sub_psel_o, sub_penable_o, sub_pwrite_o}), 128'(3'b111));
        rst_ni = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        sb_q.delete();
        mgr_psel_i    = '0;
        mgr_penable_i = '0;
        mdl_ptr       = 0;
        @(negedge clk);
        chk_all_zero("reset_hold");
        rst_ni = 1'b0;
        @(negedge clk);
        set_req(0, 32'h0000_0004, 1'b0, 32'h0);
        set_req(2, 32'h0000_0014, 1'b1, 32'h5555_AAAA);
        issue_round(3'b101);
        wait_round();

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            mask = 3'($urandom_range(1, 7));
            for (int m = 0; m < NM; m++) begin
                a = $urandom;
                case ($urandom_range(0, 9))
                    0:       a[31:28] = 4'hF;
                    1:       a[31:28] = 4'hE;
                    default: a[31:28] = 4'h0;
                endcase
                set_req(m, a, 1'($urandom), $urandom);
            end
            issue_round(mask);
            wait_round();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/zeroheti_apb_arbiter.md
# zeroheti_apb_arbiter

Round-robin APB arbiter that shares the single peripheral APB bus (the port feeding the peripheral address decoder/demux) between NumMgrs managers, e.g. the core and a DMA or debug manager. It accepts APB requests from all managers and serialises them onto one subordinate port. It re-issues each granted transfer with a clean setup/access sequence and terminates hung accesses with a timeout error. Sits between the managers and the existing APB demux; the demux and peripherals are unchanged.

## Interface
- NumMgrs, 2: number of APB managers (2..8).
- AddrWidth, 32: APB address width.
- DataWidth, 32: APB data width.
- TimeoutCycles, 255: max access-phase cycles before forced error termination; 0 disables the timeout.

- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-high.
- mgr_psel_i  in  NumMgrs  per-manager psel.
- mgr_penable_i  in  NumMgrs  per-manager penable.
- mgr_pwrite_i  in  NumMgrs  per-manager pwrite.
- mgr_paddr_i  in  NumMgrs x AddrWidth  per-manager paddr.
- mgr_pwdata_i  in  NumMgrs x DataWidth  per-manager pwdata.
- mgr_prdata_o  out  NumMgrs x DataWidth  read data, non-zero only in the completing manager's slot.
- mgr_pready_o  out  NumMgrs  one-cycle completion pulse per manager.
- mgr_pslverr_o  out  NumMgrs  error, valid with mgr_pready_o.
- sub_psel_o, sub_penable_o, sub_pwrite_o  out  1 each  subordinate control.
- sub_paddr_o  out  AddrWidth; sub_pwdata_o  out  DataWidth.
- sub_prdata_i  in  DataWidth; sub_pready_i, sub_pslverr_i  in  1.
- grant_o  out  $clog2(NumMgrs)  index of the manager owning the bus.
- busy_o  out  1  high in SETUP/ACCESS.
- timeout_o  out  1  one-cycle pulse on timeout termination.

## Operation
- FSM states IDLE, SETUP, ACCESS. Reset: IDLE, RR pointer 0, every output 0.
- IDLE: the request vector is mgr_psel_i. If it is non-zero, pick the first set bit at or after the RR pointer, wrapping. Latch the index, paddr, pwrite and pwdata. Set the pointer to (index+1) mod NumMgrs. Go to SETUP.
- SETUP: sub_psel_o=1, sub_penable_o=0, latched fields driven. Go to ACCESS.
- ACCESS: sub_psel_o=1, sub_penable_o=1. Timeout counter increments each cycle.
  - On sub_pready_i: the granted manager gets mgr_pready_o=1, mgr_prdata_o=sub_prdata_i and mgr_pslverr_o=sub_pslverr_i for that cycle. Go to IDLE.
  - If the counter reaches TimeoutCycles without pready: the granted manager gets pready=1, pslverr=1, prdata=0. timeout_o=1. Go to IDLE. sub_psel_o drops the next cycle.
- Managers not granted see pready=0 (legal APB wait states) and must hold their request stable.
- The manager's penable is not used for arbitration. A request is recognised from psel alone.
- sub_* outputs are 0 in IDLE. Write data is driven 0 in IDLE.
- If a manager deasserts psel while waiting, this is a protocol violation and is not protected. A latched request completes regardless.

## Timing
- Zero-wait subordinate: request seen in IDLE cycle N, SETUP in N+1, ACCESS and manager pready in N+2. This adds 1 cycle over direct APB.
- Back-to-back: after completion at N+2, IDLE at N+3, next SETUP at N+4. The minimum transfer period is 3 cycles.
- Simultaneous requests: strict round-robin. No manager waits for more than NumMgrs-1 transfers.
- Counter width is $clog2(TimeoutCycles+1). It resets on entry to ACCESS and saturates, so there is no wrap.
- sub_pready_i arriving in the same cycle the timeout is reached: the pready wins, and the subordinate response is forwarded with no timeout.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. The in-flight transfer is lost.

## Structure
- zeroheti_pkg gets: arb_state_e (IDLE, SETUP, ACCESS), and the default ArbTimeout constant.
- One sub-module, zeroheti_rr_pick: combinational round-robin picker. Inputs are the request vector and the pointer. Outputs are the index and a valid flag.

## Test plan
- Single read, mgr0, paddr 0x0003_0004, subordinate pready on its first access cycle with prdata 0xDEAD_BEEF -> mgr0 pready at cycle N+2 with prdata 0xDEAD_BEEF, pslverr 0; mgr1 outputs stay 0.
- Both managers assert psel in the same cycle after reset -> mgr0 served first and mgr1 second; repeat -> order alternates 0,1,0,1; grant_o tracks it.
- Subordinate never asserts pready, TimeoutCycles=8 -> manager pready+pslverr at the 8th ACCESS cycle, timeout_o pulses once, prdata 0.
- pready arriving on exactly the timeout cycle with pslverr=0 -> normal completion, timeout_o stays 0.
- Reset pulse during ACCESS of a write -> all outputs 0 during reset; FSM back in IDLE with RR pointer 0; the next request is served cleanly.
- Write from mgr1 with 3 subordinate wait states -> sub_paddr and sub_pwdata stable across SETUP/ACCESS; mgr1 pready at cycle N+5.
